// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register busy scoreboard. Register x0 always reads as zero and is never busy.
module regfile_mp_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 1,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  input  logic                 flush
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Per-register write resolution; later ports overwrite earlier ones.
  logic [NREGS-1:0] wr_hit;
  logic [XLEN-1:0]  wr_val [NREGS];

  // Resolve this cycle's writes per register, highest write port wins.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < int'(NREGS); r++) begin
      wr_val[r] = '0;
      for (int w = 0; w < int'(NWR); w++) begin
        if (r != 0 && wr_en[w] && wr_addr[w*AW +: AW] == AW'(r)) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Next-state for storage and scoreboard: flush > reserve > release > hold.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < int'(NREGS); r++) begin
      regs_d[r] = regs_q[r];
      if (wr_hit[r]) begin
        regs_d[r] = wr_val[r];
      end
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (rsv_en && rsv_addr == AW'(r)) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit[r]) begin
        busy_d[r] = 1'b0;
      end
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Combinational read ports with optional same-cycle forwarding.
  always_comb begin
    logic [AW-1:0] ra;
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < int'(NRD); p++) begin
      ra = rd_addr[p*AW +: AW];
      rd_data[p*XLEN +: XLEN] = regs_q[ra];
      rd_busy[p]              = busy_q[ra];
      if (BYPASS != 0) begin
        for (int w = 0; w < int'(NWR); w++) begin
          if (wr_en[w] && wr_addr[w*AW +: AW] == ra) begin
            rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
            rd_busy[p]              = 1'b0;
          end
        end
      end
      if (ra == '0) begin
        rd_data[p*XLEN +: XLEN] = '0;
        rd_busy[p]              = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomised and directed bench for regfile_mp_sb: one bypassing and one
// non-bypassing instance share the same stimulus and are checked against a model.
module tb_regfile_mp_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NWR   = 2;
  localparam int unsigned AW    = $clog2(NREGS);

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]      rd_busy_b, rd_busy_n;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                flush;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  logic            m_busy [NREGS];

  always #5 clk = ~clk;

  regfile_mp_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)
  ) u_byp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush)
  );

  regfile_mp_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)
  ) u_nob (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush)
  );

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got,
                          input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reads are checked against the model's architectural view of this cycle.
  task automatic check_reads();
    for (int p = 0; p < int'(NRD); p++) begin
      int              a;
      logic [XLEN-1:0] eb_d, en_d;
      logic            eb_b, en_b;
      a    = int'(rd_addr[p*AW +: AW]);
      en_d = m_regs[a];
      en_b = m_busy[a];
      eb_d = en_d;
      eb_b = en_b;
      for (int w = 0; w < int'(NWR); w++) begin
        if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) begin
          eb_d = wr_data[w*XLEN +: XLEN];
          eb_b = 1'b0;
        end
      end
      if (a == 0) begin
        eb_d = '0; en_d = '0; eb_b = 1'b0; en_b = 1'b0;
      end
      check_eq("byp_rd_data", rd_data_b[p*XLEN +: XLEN], eb_d);
      check_eq("byp_rd_busy", XLEN'(rd_busy_b[p]), XLEN'(eb_b));
      check_eq("nob_rd_data", rd_data_n[p*XLEN +: XLEN], en_d);
      check_eq("nob_rd_busy", XLEN'(rd_busy_n[p]), XLEN'(en_b));
    end
  endtask

  // Architectural effect of one clock edge given the current inputs.
  task automatic model_edge();
    logic [XLEN-1:0] nv [NREGS];
    logic            wr [NREGS];
    if (!rst_n) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
      return;
    end
    for (int r = 0; r < int'(NREGS); r++) begin
      nv[r] = m_regs[r];
      wr[r] = 1'b0;
    end
    for (int w = 0; w < int'(NWR); w++) begin
      int a;
      a = int'(wr_addr[w*AW +: AW]);
      if (wr_en[w] && a != 0) begin
        nv[a] = wr_data[w*XLEN +: XLEN];
        wr[a] = 1'b1;
      end
    end
    for (int r = 1; r < int'(NREGS); r++) begin
      m_regs[r] = nv[r];
      if (flush) m_busy[r] = 1'b0;
      else if (rsv_en && int'(rsv_addr) == r) m_busy[r] = 1'b1;
      else if (wr[r]) m_busy[r] = 1'b0;
    end
  endtask

  task automatic step();
    #2;
    check_reads();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0; rd_addr = '0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    for (int r = 0; r < int'(NREGS); r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    @(posedge clk);
    #1;
    // Reset state
    set_rd(5, 31);
    step();

    // T1: write then reset clears it, including a write in the reset cycle
    idle(); wr_en = 2'b01; wr_addr = {AW'(0), AW'(5)}; wr_data = {32'h0, 32'hDEADBEEF};
    step();
    idle(); set_rd(5, 0); #1;
    check_eq("t1_written", rd_data_n[XLEN-1:0], 32'hDEADBEEF);
    rst_n = 1'b0; wr_en = 2'b01; wr_addr = {AW'(0), AW'(5)}; wr_data = {32'h0, 32'h1};
    rsv_en = 1'b1; rsv_addr = AW'(6);
    step();
    idle(); set_rd(5, 6); #1;
    check_eq("t1_reset_data", rd_data_n[XLEN-1:0], 32'h0);
    check_eq("t1_reset_busy", XLEN'(rd_busy_n), 32'h0);
    step();

    // T2: x0 writes and reserves are ignored
    idle(); wr_en = 2'b11; wr_addr = '0; wr_data = {32'h5678, 32'h1234};
    rsv_en = 1'b1; rsv_addr = '0; set_rd(0, 0); #1;
    check_eq("t2_x0_byp", rd_data_b, 64'h0);
    step();
    idle(); set_rd(0, 0); #1;
    check_eq("t2_x0_data", rd_data_n, 64'h0);
    check_eq("t2_x0_busy", XLEN'({rd_busy_b, rd_busy_n}), 32'h0);
    step();

    // T3: same-cycle bypass vs stored value
    idle(); wr_en = 2'b01; wr_addr = {AW'(0), AW'(7)}; wr_data = {32'h0, 32'hA5A5A5A5};
    set_rd(7, 7); #1;
    check_eq("t3_byp_data", rd_data_b[XLEN-1:0], 32'hA5A5A5A5);
    check_eq("t3_byp_busy", XLEN'(rd_busy_b[0]), 32'h0);
    check_eq("t3_nob_data", rd_data_n[XLEN-1:0], 32'h0);
    step();

    // T4: write-port collision, highest port wins
    idle(); wr_en = 2'b11; wr_addr = {AW'(3), AW'(3)}; wr_data = {32'h22, 32'h11};
    set_rd(3, 3); #1;
    check_eq("t4_byp_collide", rd_data_b[XLEN-1:0], 32'h22);
    step();
    idle(); set_rd(3, 0); #1;
    check_eq("t4_stored", rd_data_n[XLEN-1:0], 32'h22);
    step();

    // T5: scoreboard reserve / release ordering
    idle(); rsv_en = 1'b1; rsv_addr = AW'(9); set_rd(9, 9); #1;
    check_eq("t5_rsv_same_cycle", XLEN'(rd_busy_n[0]), 32'h0);
    step();
    idle(); set_rd(9, 9); #1;
    check_eq("t5_busy_after_rsv", XLEN'(rd_busy_n[0]), 32'h1);
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(9)}; wr_data = {32'h0, 32'h55};
    rsv_en = 1'b1; rsv_addr = AW'(9);
    step();
    idle(); set_rd(9, 0); #1;
    check_eq("t5_data", rd_data_n[XLEN-1:0], 32'h55);
    check_eq("t5_still_busy", XLEN'(rd_busy_n[0]), 32'h1);
    wr_en = 2'b10; wr_addr = {AW'(9), AW'(0)}; wr_data = {32'h66, 32'h0};
    step();
    idle(); set_rd(9, 0); #1;
    check_eq("t5_released", XLEN'(rd_busy_n[0]), 32'h0);
    step();

    // T6: flush clears all busy bits but keeps a same-cycle write
    for (int i = 0; i < 3; i++) begin
      idle(); rsv_en = 1'b1; rsv_addr = (i == 2) ? AW'(4) : AW'(i + 1);
      step();
    end
    idle(); set_rd(1, 4); #1;
    check_eq("t6_pre_busy", XLEN'(rd_busy_n), 32'h3);
    flush = 1'b1; wr_en = 2'b01; wr_addr = {AW'(0), AW'(2)}; wr_data = {32'h0, 32'h77};
    step();
    idle(); set_rd(2, 3); #1;
    check_eq("t6_x2", rd_data_n[XLEN-1:0], 32'h77);
    check_eq("t6_x3", rd_data_n[2*XLEN-1:XLEN], 32'h22);
    step();
    idle(); set_rd(1, 4); #1;
    check_eq("t6_flushed", XLEN'(rd_busy_n), 32'h0);
    step();

    // Random traffic, addresses biased to a small window to force collisions
    for (int n = 0; n < 600; n++) begin
      int lim;
      lim      = ($urandom_range(0, 1) == 0) ? 7 : 31;
      rst_n    = ($urandom_range(0, 60) != 0);
      wr_en    = NWR'($urandom_range(0, 3));
      wr_addr  = {AW'($urandom_range(0, lim)), AW'($urandom_range(0, lim))};
      wr_data  = {$urandom, $urandom};
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = AW'($urandom_range(0, lim));
      flush    = ($urandom_range(0, 15) == 0);
      set_rd($urandom_range(0, lim), $urandom_range(0, lim));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
